// File: rtl/uart_pkg.sv
// Shared UART constants: byte width, default baud divider, default TX FIFO depth.
// Latency: none (constants and types only).
// Backpressure: not applicable.
package uart_pkg;
    localparam int UART_BYTE_W   = 8;
    localparam int CLK_CYCLES    = 868;   // 100 MHz core clock / 115200 baud
    localparam int DEPTH_LOG_DEF = 4;

    typedef logic [UART_BYTE_W-1:0] byte_t;
endpackage

// File: rtl/fifo_regfile.sv
// DEPTH x byte register array, one synchronous write port, one asynchronous read port.
// Latency: write visible on the read port the cycle after the write edge.
// Backpressure: none; the caller gates we.
module fifo_regfile
    import uart_pkg::*;
#(
    parameter int DEPTH_LOG = DEPTH_LOG_DEF
) (
    input  logic                 clk,
    input  logic                 we,
    input  logic [DEPTH_LOG-1:0] waddr,
    input  byte_t                wdata,
    input  logic [DEPTH_LOG-1:0] raddr,
    output byte_t                rdata
);
    localparam int DEPTH = 1 << DEPTH_LOG;

    byte_t mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];
endmodule

// File: rtl/uart_tx_fifo.sv
// Show-ahead byte FIFO feeding a uart_transmitter; optional drop counter under UART_TX_FIFO_DROP_CNT_EN.
// Latency: byte written into an empty FIFO raises tx_req the next cycle; no bypass.
// Backpressure: pops only on tx_req && tx_ready; writes to a full FIFO without a pop are dropped (sticky overflow).
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH_LOG = DEPTH_LOG_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  byte_t                wr_data,
    input  logic                 wr_en,
    output logic                 full,
    output logic [DEPTH_LOG:0]   count,
    output logic                 overflow,
    input  logic                 clr_overflow,
    output byte_t                tx_data,
    output logic                 tx_req,
    input  logic                 tx_ready
`ifdef UART_TX_FIFO_DROP_CNT_EN
    ,
    output logic [7:0]           drop_cnt
`endif
);
    localparam int DEPTH = 1 << DEPTH_LOG;
    localparam logic [DEPTH_LOG:0] DEPTH_CNT = (DEPTH_LOG+1)'(DEPTH);

    logic [DEPTH_LOG-1:0] wptr_q, wptr_d;
    logic [DEPTH_LOG-1:0] rptr_q, rptr_d;
    logic [DEPTH_LOG:0]   count_q, count_d;
    logic                 overflow_q, overflow_d;
    logic                 pop, wr_acc, drop;

    // tx_req depends on registered count only, so the transmitter never sees a loop through tx_ready.
    assign tx_req   = (count_q != '0);
    assign full     = (count_q == DEPTH_CNT);
    assign count    = count_q;
    assign overflow = overflow_q;

    always_comb begin
        pop        = tx_req && tx_ready;
        wr_acc     = wr_en && (!full || pop);
        drop       = wr_en && !wr_acc;
        wptr_d     = wptr_q;
        rptr_d     = rptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        if (wr_acc) begin
            wptr_d = wptr_q + DEPTH_LOG'(1);
        end
        if (pop) begin
            rptr_d = rptr_q + DEPTH_LOG'(1);
        end
        case ({wr_acc, pop})
            2'b10:   count_d = count_q + (DEPTH_LOG+1)'(1);
            2'b01:   count_d = count_q - (DEPTH_LOG+1)'(1);
            default: count_d = count_q;
        endcase
        if (clr_overflow) begin
            overflow_d = 1'b0;
        end
        if (drop) begin
            overflow_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q     <= '0;
            rptr_q     <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

`ifdef UART_TX_FIFO_DROP_CNT_EN
    logic [7:0] drop_cnt_q, drop_cnt_d;

    // A clear and a drop in the same cycle restart the count at this drop.
    always_comb begin
        drop_cnt_d = clr_overflow ? 8'd0 : drop_cnt_q;
        if (drop && drop_cnt_d != 8'hFF) begin
            drop_cnt_d = drop_cnt_d + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            drop_cnt_q <= 8'd0;
        end else begin
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign drop_cnt = drop_cnt_q;
`endif

    fifo_regfile #(
        .DEPTH_LOG (DEPTH_LOG)
    ) u_regfile (
        .clk   (clk),
        .we    (wr_acc && !rst),
        .waddr (wptr_q),
        .wdata (wr_data),
        .raddr (rptr_q),
        .rdata (tx_data)
    );
endmodule

// File: tb/tb_uart_tx_fifo.sv
// Scoreboard bench for uart_tx_fifo: expected bytes queued at issue, checked by a negedge pop monitor.
module tb_uart_tx_fifo;
    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] wr_data;
    logic       wr_en;
    logic       full;
    logic [4:0] count;
    logic       overflow;
    logic       clr_overflow;
    logic [7:0] tx_data;
    logic       tx_req;
    logic       tx_ready;
`ifdef UART_TX_FIFO_DROP_CNT_EN
    logic [7:0] drop_cnt;
`endif

    int n_chk  = 0;
    int n_fail = 0;
    logic [7:0] exp_q [$];

    always #5 clk = ~clk;

    uart_tx_fifo #(.DEPTH_LOG(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .wr_data      (wr_data),
        .wr_en        (wr_en),
        .full         (full),
        .count        (count),
        .overflow     (overflow),
        .clr_overflow (clr_overflow),
        .tx_data      (tx_data),
        .tx_req       (tx_req),
        .tx_ready     (tx_ready)
`ifdef UART_TX_FIFO_DROP_CNT_EN
        ,
        .drop_cnt     (drop_cnt)
`endif
    );

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    // Monitor: a pop happens at the next edge whenever tx_req && tx_ready.
    always @(negedge clk) begin
        if (!rst && tx_req && tx_ready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_pop", 32'(tx_data), -1);
            end else begin
                chk("tx_data_order", 32'(tx_data), 32'(exp_q.pop_front()));
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [7:0] b, input bit expect_acc);
        wr_en   = 1'b1;
        wr_data = b;
        if (expect_acc) exp_q.push_back(b);
        cyc();
        wr_en   = 1'b0;
    endtask

    task automatic drain(input string name);
        wr_en    = 1'b0;
        tx_ready = 1'b1;
        for (int i = 0; i < 64; i++) begin
            if (count == 0) break;
            cyc();
        end
        cyc();
        chk({name, "_count"}, 32'(count), 0);
        chk({name, "_sb_empty"}, exp_q.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int sent;
        rst = 1'b1; wr_en = 1'b0; wr_data = 8'h00; clr_overflow = 1'b0; tx_ready = 1'b0;
        cyc(); cyc();
        rst = 1'b0;
        cyc();
        chk("reset_count", 32'(count), 0);
        chk("reset_full", 32'(full), 0);
        chk("reset_tx_req", 32'(tx_req), 0);
        chk("reset_overflow", 32'(overflow), 0);

        // Three bytes with the transmitter always ready.
        tx_ready = 1'b1;
        wr(8'h41, 1'b1);
        chk("first_write_tx_req", 32'(tx_req), 1);
        chk("first_write_tx_data", 32'(tx_data), 8'h41);
        wr(8'h42, 1'b1);
        wr(8'h43, 1'b1);
        drain("abc");

        // Fill 16 with the transmitter stalled, then drop the 17th.
        tx_ready = 1'b0;
        for (int i = 0; i < 16; i++) wr(8'(8'h50 + i), 1'b1);
        chk("fill_count", 32'(count), 16);
        chk("fill_full", 32'(full), 1);
        chk("fill_overflow", 32'(overflow), 0);
        chk("stall_tx_data", 32'(tx_data), 8'h50);
        wr(8'hEE, 1'b0);
        chk("drop_count", 32'(count), 16);
        chk("drop_overflow", 32'(overflow), 1);
`ifdef UART_TX_FIFO_DROP_CNT_EN
        chk("drop_cnt_one", 32'(drop_cnt), 1);
`endif
        // Clear and drop together: the drop wins.
        clr_overflow = 1'b1;
        wr(8'hEF, 1'b0);
        clr_overflow = 1'b0;
        chk("clr_vs_drop_overflow", 32'(overflow), 1);
        clr_overflow = 1'b1;
        cyc();
        clr_overflow = 1'b0;
        chk("clr_overflow", 32'(overflow), 0);
`ifdef UART_TX_FIFO_DROP_CNT_EN
        chk("clr_drop_cnt", 32'(drop_cnt), 0);
`endif

        // Full FIFO with write and pop together.
        tx_ready = 1'b1;
        wr(8'h99, 1'b1);
        tx_ready = 1'b0;
        chk("full_wr_pop_count", 32'(count), 16);
        chk("full_wr_pop_overflow", 32'(overflow), 0);
        drain("full_drain");

        // 40-byte stream with random backpressure, wrapping the pointers twice.
        sent = 0;
        for (int c = 0; c < 2000 && sent < 40; c++) begin
            tx_ready = 1'($urandom_range(0, 1));
            if (!full) begin
                wr_en   = 1'b1;
                wr_data = 8'(sent);
                exp_q.push_back(8'(sent));
                sent++;
            end else begin
                wr_en = 1'b0;
            end
            cyc();
        end
        wr_en = 1'b0;
        chk("stream_sent", sent, 40);
        drain("stream");
        chk("stream_overflow", 32'(overflow), 0);

        // Reset with five bytes stored and a write pending.
        tx_ready = 1'b0;
        for (int i = 0; i < 5; i++) wr(8'(8'hA0 + i), 1'b0);
        chk("pre_rst_count", 32'(count), 5);
        rst = 1'b1; wr_en = 1'b1; wr_data = 8'hAA;
        cyc();
        rst = 1'b0; wr_en = 1'b0;
        chk("rst_count", 32'(count), 0);
        chk("rst_tx_req", 32'(tx_req), 0);
        chk("rst_overflow", 32'(overflow), 0);
        cyc();
        chk("post_rst_tx_req", 32'(tx_req), 0);

        // FIFO restarts cleanly at pointer 0.
        tx_ready = 1'b1;
        wr(8'h5A, 1'b1);
        wr(8'hC3, 1'b1);
        drain("post_rst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
